// File: rtl/trace_pkg.sv
// Shared types for the waveform capture stage.
//   state_t       : capture controller states
//   trace_entry_t : one recorded event {ts, value} at the default block widths
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam int TRACE_WIDTH    = 1;
    localparam int TRACE_TS_WIDTH = 16;

    typedef struct packed {
        logic [TRACE_TS_WIDTH-1:0] ts;
        logic [TRACE_WIDTH-1:0]    value;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO for trace entries.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with a pop)
//   pop        : remove head entry (ignored when empty)
//   pop_data   : head entry; holds the last popped entry while empty
//   full, empty, level : occupancy status
module trace_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [DATA_W-1:0] last_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign level   = count;

    // While empty, present the last popped entry so the read data stays stable.
    assign pop_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Waveform capture stage: records every change of the probed signal as a
// {timestamp, value} entry in a FWFT FIFO drained through a valid/ready port.
//   clk, reset          : simulation clock, synchronous active-high reset
//   start, stop         : begin / end a capture run
//   probe               : monitored signal
//   rd_ready            : consumer accepts the head entry
//   rd_valid, rd_ts, rd_value : head entry presentation
//   busy, done          : controller in CAPTURE / DONE
//   overflow            : sticky, an event was dropped during this run
//   level               : FIFO occupancy
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset; waits for start
// CAPTURE | timestamp running, changes of probe are queued
// DONE    | run ended (stop, timestamp saturation or overflow); a new
//         | start is accepted only once the FIFO has been drained
module trace_capture #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [WIDTH-1:0]           probe,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_WIDTH-1:0]        rd_ts,
    output logic [WIDTH-1:0]           rd_value,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    import trace_pkg::*;

    localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

    state_t                     state_q, state_d;
    logic [TS_WIDTH-1:0]        ts_q, ts_d;
    logic [WIDTH-1:0]           prev_q, prev_d;
    logic                       ovf_q, ovf_d;
    logic                       push;
    logic [TS_WIDTH+WIDTH-1:0]  push_data;
    logic [TS_WIDTH+WIDTH-1:0]  head_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop_now;

    assign pop_now = rd_ready && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        prev_d    = prev_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_data = {ts_q, probe};
        unique case (state_q)
            IDLE, DONE: begin
                if (start && (state_q == IDLE || fifo_empty)) begin
                    push      = 1'b1;
                    push_data = {TS_WIDTH'(0), probe};
                    ts_d      = TS_WIDTH'(1);
                    prev_d    = probe;
                    ovf_d     = 1'b0;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                prev_d = probe;
                if (ts_q != TS_MAX) begin
                    ts_d = ts_q + TS_WIDTH'(1);
                end
                if (probe != prev_q) begin
                    if (!fifo_full || pop_now) begin
                        push = 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                // Saturate rather than wrap so timestamps stay monotonic.
                if (stop || ts_q == TS_MAX) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            prev_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
        end
    end

    trace_fifo #(
        .DATA_W (TS_WIDTH + WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_now),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign rd_valid = !fifo_empty;
    assign rd_ts    = head_data[TS_WIDTH+WIDTH-1:WIDTH];
    assign rd_value = head_data[WIDTH-1:0];
    assign busy     = (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a small FIFO and a short timestamp
// so overflow and saturation are reachable in a few cycles.
module tb_trace_capture;

    localparam int WIDTH    = 1;
    localparam int DEPTH    = 4;
    localparam int TS_WIDTH = 4;
    localparam int LVL_W    = $clog2(DEPTH+1);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                stop;
    logic [WIDTH-1:0]    probe;
    logic                rd_ready;
    logic                rd_valid;
    logic [TS_WIDTH-1:0] rd_ts;
    logic [WIDTH-1:0]    rd_value;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [LVL_W-1:0]    level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_capture #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TS_WIDTH (TS_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .probe    (probe),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_ts    (rd_ts),
        .rd_value (rd_value),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .level    (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0d exp=0", rd_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0d exp=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0d exp=0", overflow); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        total++; if (rd_ts !== 4'd0) begin bad++; $display("FAIL rst_rd_ts got=%0d exp=0", rd_ts); end
        total++; if (rd_value !== 1'b0) begin bad++; $display("FAIL rst_rd_value got=%0d exp=0", rd_value); end
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%0d exp=0", busy); end
    endtask

    // start and stop together in IDLE: start wins; then a flat probe run.
    task automatic test_single();
        start = 1'b1; stop = 1'b1; probe = 1'b0;
        tick();
        start = 1'b0; stop = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0d exp=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_early got=%0d exp=0", done); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level0 got=%0d exp=1", level); end
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%0d exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%0d exp=0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_overflow got=%0d exp=0", overflow); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%0d exp=1", rd_valid); end
        total++; if (rd_ts !== 4'd0) begin bad++; $display("FAIL single_ts got=%0d exp=0", rd_ts); end
        total++; if (rd_value !== 1'b0) begin bad++; $display("FAIL single_value got=%0d exp=0", rd_value); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0d exp=0", rd_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL single_level_drained got=%0d exp=0", level); end
    endtask

    // Toggles at cycles 3, 7 and 8 after start.
    task automatic test_toggles();
        logic [3:0] ets [4];
        logic       evs [4];
        ets = '{4'd0, 4'd3, 4'd7, 4'd8};
        evs = '{1'b0, 1'b1, 1'b0, 1'b1};
        start = 1'b1; probe = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            probe = ((k >= 3 && k < 7) || k >= 8) ? 1'b1 : 1'b0;
            tick();
            if (k == 3) begin
                total++; if (level !== 3'd2) begin bad++; $display("FAIL tog_level_latency got=%0d exp=2", level); end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL tog_level got=%0d exp=4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL tog_overflow got=%0d exp=0", overflow); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL tog_done got=%0d exp=1", done); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL tog_valid[%0d] got=%0d exp=1", i, rd_valid); end
            total++; if (rd_ts !== ets[i]) begin bad++; $display("FAIL tog_ts[%0d] got=%0d exp=%0d", i, rd_ts, ets[i]); end
            total++; if (rd_value !== evs[i]) begin bad++; $display("FAIL tog_value[%0d] got=%0d exp=%0d", i, rd_value, evs[i]); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL tog_drained got=%0d exp=0", rd_valid); end
    endtask

    // Probe toggles every cycle with no reads: fourth change is dropped.
    task automatic test_overflow();
        logic [3:0] ets [4];
        logic       evs [4];
        ets = '{4'd0, 4'd1, 4'd2, 4'd3};
        evs = '{1'b0, 1'b1, 1'b0, 1'b1};
        start = 1'b1; probe = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            probe = k[0];
            tick();
        end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level_full got=%0d exp=4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0d exp=0", overflow); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%0d exp=1", busy); end
        probe = 1'b0;
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", overflow); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%0d exp=1", done); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_ts !== ets[i]) begin bad++; $display("FAIL ovf_ts[%0d] got=%0d exp=%0d", i, rd_ts, ets[i]); end
            total++; if (rd_value !== evs[i]) begin bad++; $display("FAIL ovf_value[%0d] got=%0d exp=%0d", i, rd_value, evs[i]); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", overflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", rd_valid); end
    endtask

    // Full FIFO with simultaneous push and pop every cycle.
    task automatic test_back_to_back();
        logic [3:0] ets [4];
        logic       evs [4];
        ets = '{4'd4, 4'd5, 4'd6, 4'd7};
        evs = '{1'b0, 1'b1, 1'b0, 1'b1};
        start = 1'b1; probe = 1'b0;
        tick();
        start = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_cleared got=%0d exp=0", overflow); end
        for (int k = 1; k <= 3; k++) begin
            probe = k[0];
            tick();
        end
        rd_ready = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            total++; if (rd_ts !== 4'(k - 4)) begin bad++; $display("FAIL b2b_head_ts[%0d] got=%0d exp=%0d", k, rd_ts, k - 4); end
            probe = k[0];
            tick();
            total++; if (level !== 3'd4) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=4", k, level); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow[%0d] got=%0d exp=0", k, overflow); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d] got=%0d exp=1", k, busy); end
        end
        rd_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL b2b_level_end got=%0d exp=4", level); end
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_ts !== ets[i]) begin bad++; $display("FAIL b2b_ts[%0d] got=%0d exp=%0d", i, rd_ts, ets[i]); end
            total++; if (rd_value !== evs[i]) begin bad++; $display("FAIL b2b_value[%0d] got=%0d exp=%0d", i, rd_value, evs[i]); end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
    endtask

    // No stop: run ends when the timestamp reaches 15; restart gated on drain.
    task automatic test_saturation();
        start = 1'b1; probe = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sat_busy_ts14 got=%0d exp=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL sat_done_ts14 got=%0d exp=0", done); end
        probe = 1'b1;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done got=%0d exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_busy got=%0d exp=0", busy); end
        total++; if (level !== 3'd2) begin bad++; $display("FAIL sat_level got=%0d exp=2", level); end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_start_ignored_done got=%0d exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sat_start_ignored_busy got=%0d exp=0", busy); end
        total++; if (level !== 3'd2) begin bad++; $display("FAIL sat_start_ignored_level got=%0d exp=2", level); end
        total++; if (rd_ts !== 4'd0) begin bad++; $display("FAIL sat_ts0 got=%0d exp=0", rd_ts); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++; if (rd_ts !== 4'd15) begin bad++; $display("FAIL sat_ts15 got=%0d exp=15", rd_ts); end
        total++; if (rd_value !== 1'b1) begin bad++; $display("FAIL sat_val15 got=%0d exp=1", rd_value); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL sat_drained got=%0d exp=0", rd_valid); end
        start = 1'b1; probe = 1'b1;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sat_restart_busy got=%0d exp=1", busy); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL sat_restart_level got=%0d exp=1", level); end
        total++; if (rd_ts !== 4'd0) begin bad++; $display("FAIL sat_restart_ts got=%0d exp=0", rd_ts); end
        total++; if (rd_value !== 1'b1) begin bad++; $display("FAIL sat_restart_value got=%0d exp=1", rd_value); end
    endtask

    // Continues the run restarted above; reset with entries queued.
    task automatic test_reset_mid_run();
        probe = 1'b0;
        tick();
        probe = 1'b1;
        tick();
        total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_level got=%0d exp=3", level); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%0d exp=1", rd_valid); end
        reset = 1'b1; start = 1'b1; rd_ready = 1'b1;
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0d exp=0", rd_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_rst_level got=%0d exp=0", level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0d exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%0d exp=0", done); end
        total++; if (rd_ts !== 4'd0) begin bad++; $display("FAIL mid_rst_ts got=%0d exp=0", rd_ts); end
        reset = 1'b0; start = 1'b0; rd_ready = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_after_busy got=%0d exp=0", busy); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_after_level got=%0d exp=0", level); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; probe = 1'b0; rd_ready = 1'b0;
        test_reset();
        test_single();
        test_toggles();
        test_overflow();
        test_back_to_back();
        test_saturation();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
